memory_access_stage: RTL and testbench

- Pipeline MEM stage and consumer of the 75-bit EX/MEM bundle produced by the execution stage.
- Performs the data-memory load/store against an internal word-addressed RAM with configurable access latency.
- Drives a stall back to the execution side while an access is in flight.
- Emits the 71-bit MEM/WB bundle plus exception flags to writeback.

---
 rtl/memory_access_stage.sv | 205 ++++++++++++++++++++
 tb/tb_memory_access_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM pipeline stage with latency-modelled data RAM
module memory_access_stage #(
  parameter int DEPTH       = 256,
  parameter int ADDR_BITS   = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [74:0] ex_mem_reg,
  input  logic        ex_valid,
  output logic        stall_out,
  output logic [70:0] mem_wb_reg,
  output logic        wb_valid,
  output logic        overflow_exc,
  output logic        misaligned_exc
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t r_state;
  state_t w_next_state;

  // Data memory; contents survive reset
  logic [31:0] r_mem [DEPTH];

  // Holding registers for an instruction parked in ACCESS
  logic [31:0] r_alu;
  logic [31:0] r_data2;
  logic [4:0]  r_wr;
  logic        r_m2r;
  logic        r_rw_eff;
  logic        r_mr;
  logic        r_we;
  logic        r_ovf;
  logic [3:0]  r_count;

  // Field decode of the incoming EX/MEM bundle
  logic [31:0] w_ex_alu;
  logic [31:0] w_ex_d2;
  logic [4:0]  w_ex_wr;
  logic        w_ex_ovf;
  logic        w_ex_mr;
  logic        w_ex_m2r;
  logic        w_ex_mw;
  logic        w_ex_rw;
  logic        w_unused_zero;

  assign w_ex_alu      = ex_mem_reg[31:0];
  assign w_ex_d2       = ex_mem_reg[63:32];
  assign w_ex_wr       = ex_mem_reg[68:64];
  assign w_unused_zero = ex_mem_reg[69];
  assign w_ex_ovf      = ex_mem_reg[70];
  assign w_ex_mr       = ex_mem_reg[71];
  assign w_ex_m2r      = ex_mem_reg[72];
  assign w_ex_mw       = ex_mem_reg[73];
  assign w_ex_rw       = ex_mem_reg[74];

  logic w_accept;
  logic w_ex_memop;
  logic w_ex_mis;
  logic w_ex_slow;
  logic w_fast_done;
  logic w_slow_done;
  logic w_go_access;
  logic w_done;

  assign w_accept    = (r_state == S_IDLE) && ex_valid;
  assign w_ex_memop  = w_ex_mr | w_ex_mw;
  assign w_ex_mis    = w_ex_memop && (w_ex_alu[1:0] != 2'b00);
  // Only aligned memory ops pay the latency; misaligned ones finish like ALU ops
  assign w_ex_slow   = w_ex_memop && !w_ex_mis && (MEM_LATENCY != 0);
  assign w_fast_done = w_accept && !w_ex_slow;
  assign w_go_access = w_accept && w_ex_slow;
  assign w_slow_done = (r_state == S_ACCESS) && (r_count == 4'd1);
  assign w_done      = w_fast_done || w_slow_done;

  // Single RAM port shared between the immediate path and the parked access
  logic [ADDR_BITS-1:0] w_ram_idx;
  logic [31:0]          w_ram_rdata;
  logic [31:0]          w_ram_wdata;
  logic                 w_ram_we;

  assign w_ram_idx   = (r_state == S_ACCESS) ? r_alu[ADDR_BITS+1:2] : w_ex_alu[ADDR_BITS+1:2];
  assign w_ram_wdata = (r_state == S_ACCESS) ? r_data2 : w_ex_d2;
  assign w_ram_rdata = r_mem[w_ram_idx];
  assign w_ram_we    = !rst &&
                       ((w_fast_done && w_ex_mw && !w_ex_mis && !w_ex_ovf) ||
                        (w_slow_done && r_we));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: enter ACCESS for slow memory ops, leave on the final count
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_go_access) w_next_state = S_ACCESS;
      S_ACCESS: if (w_slow_done) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Stall decoded purely from the registered state
  always_comb begin
    stall_out = (r_state == S_ACCESS);
  end

  // Latency counter: loaded on entry to ACCESS, counts down each ACCESS edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 4'd0;
    end else if (w_go_access) begin
      r_count <= 4'(MEM_LATENCY);
    end else if (r_state == S_ACCESS) begin
      r_count <= r_count - 4'd1;
    end
  end

  // Capture the accepted instruction with exceptions already folded in
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu    <= '0;
      r_data2  <= '0;
      r_wr     <= '0;
      r_m2r    <= 1'b0;
      r_rw_eff <= 1'b0;
      r_mr     <= 1'b0;
      r_we     <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_alu    <= w_ex_alu;
      r_data2  <= w_ex_d2;
      r_wr     <= w_ex_wr;
      r_m2r    <= w_ex_m2r;
      r_rw_eff <= w_ex_rw && !w_ex_ovf;
      r_mr     <= w_ex_mr;
      r_we     <= w_ex_mw && !w_ex_ovf;
      r_ovf    <= w_ex_ovf;
    end
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_idx] <= w_ram_wdata;
    end
  end

  // Result selection for whichever path completes this edge
  logic [31:0] w_res_alu;
  logic [31:0] w_res_rd;
  logic [4:0]  w_res_wr;
  logic        w_res_m2r;
  logic        w_res_rw;
  logic        w_res_ovf;
  logic        w_res_mis;

  always_comb begin
    w_res_alu = w_ex_alu;
    w_res_rd  = 32'd0;
    w_res_wr  = w_ex_wr;
    w_res_m2r = w_ex_m2r;
    w_res_rw  = 1'b0;
    w_res_ovf = 1'b0;
    w_res_mis = 1'b0;
    if (w_slow_done) begin
      w_res_alu = r_alu;
      w_res_rd  = r_mr ? w_ram_rdata : 32'd0;
      w_res_wr  = r_wr;
      w_res_m2r = r_m2r;
      w_res_rw  = r_rw_eff;
      w_res_ovf = r_ovf;
      w_res_mis = 1'b0;
    end else begin
      w_res_rd  = (w_ex_mr && !w_ex_mis) ? w_ram_rdata : 32'd0;
      w_res_rw  = w_ex_rw && !w_ex_ovf && !w_ex_mis;
      w_res_ovf = w_ex_ovf;
      w_res_mis = w_ex_mis;
    end
  end

  // MEM/WB bundle holds between completions; pulses last one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wb_reg     <= '0;
      wb_valid       <= 1'b0;
      overflow_exc   <= 1'b0;
      misaligned_exc <= 1'b0;
    end else begin
      wb_valid       <= w_done;
      overflow_exc   <= w_done && w_res_ovf;
      misaligned_exc <= w_done && w_res_mis;
      if (w_done) begin
        mem_wb_reg <= {w_res_rw, w_res_m2r, w_res_wr, w_res_rd, w_res_alu};
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - randomized self-checking bench for memory_access_stage
module tb_memory_access_stage;

  localparam int L = 2;

  logic        clk;
  logic        rst;
  logic [74:0] ex_mem_reg;
  logic        ex_valid;
  logic        stall_out;
  logic [70:0] mem_wb_reg;
  logic        wb_valid;
  logic        overflow_exc;
  logic        misaligned_exc;

  int n_vec;
  int n_err;

  logic [31:0] model_mem [256];

  memory_access_stage #(.DEPTH(256), .ADDR_BITS(8), .MEM_LATENCY(L)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_mem_reg     (ex_mem_reg),
    .ex_valid       (ex_valid),
    .stall_out      (stall_out),
    .mem_wb_reg     (mem_wb_reg),
    .wb_valid       (wb_valid),
    .overflow_exc   (overflow_exc),
    .misaligned_exc (misaligned_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [74:0] mk(input logic rw, input logic mw, input logic m2r,
                                     input logic mr, input logic ovf, input logic [4:0] wr,
                                     input logic [31:0] d2, input logic [31:0] alu);
    return {rw, mw, m2r, mr, ovf, 1'($urandom), wr, d2, alu};
  endfunction

  // Issue one instruction at a negedge with the stage idle and follow it to completion
  task automatic run_op(input logic [74:0] b, input string tag);
    logic [31:0] alu;
    logic        memop, mis, ovf;
    logic [7:0]  idx;
    logic [31:0] rd;
    logic        rw;
    int          lat;
    logic [70:0] exp_wb;
    alu   = b[31:0];
    memop = b[71] | b[73];
    mis   = memop && (alu % 4 != 0);
    ovf   = b[70];
    idx   = 8'((alu / 4) % 256);
    rd    = (b[71] && !mis) ? model_mem[idx] : 32'd0;
    if (b[73] && !mis && !ovf) model_mem[idx] = b[63:32];
    rw    = b[74] && !ovf && !mis;
    lat   = (memop && !mis) ? L : 0;
    exp_wb = {rw, b[72], b[68:64], rd, alu};

    ex_mem_reg = b;
    ex_valid   = 1'b1;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      chk({tag, " stall"}, 75'(stall_out), 75'(1));
      chk({tag, " early_wb"}, 75'(wb_valid), 75'(0));
      ex_valid   = 1'($urandom);
      ex_mem_reg = {$urandom, $urandom, $urandom};
    end
    @(negedge clk);
    ex_valid = 1'b0;
    chk({tag, " stall_done"}, 75'(stall_out), 75'(0));
    chk({tag, " wb_valid"}, 75'(wb_valid), 75'(1));
    chk({tag, " mem_wb"}, 75'(mem_wb_reg), 75'(exp_wb));
    chk({tag, " ovf_exc"}, 75'(overflow_exc), 75'(ovf));
    chk({tag, " mis_exc"}, 75'(misaligned_exc), 75'(mis));
  endtask

  task automatic idle_cycle();
    ex_valid   = 1'b0;
    ex_mem_reg = {$urandom, $urandom, $urandom};
    @(negedge clk);
    chk("idle wb", 75'(wb_valid), 75'(0));
    chk("idle stall", 75'(stall_out), 75'(0));
  endtask

  function automatic logic [31:0] rnd_addr(input logic allow_mis);
    logic [31:0] a;
    a = $urandom;
    a[1:0] = (allow_mis && $urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return a;
  endfunction

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    ex_valid   = 1'b0;
    ex_mem_reg = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst mem_wb", 75'(mem_wb_reg), 75'(0));
    chk("rst wb_valid", 75'(wb_valid), 75'(0));
    chk("rst stall", 75'(stall_out), 75'(0));
    chk("rst exc", 75'({overflow_exc, misaligned_exc}), 75'(0));

    // ALU op
    run_op(mk(1, 0, 0, 0, 0, 5'd17, 32'h0, 32'd10), "alu");
    idle_cycle();

    // Fill memory so every later load is defined
    for (int i = 0; i < 256; i++) begin
      logic [31:0] a;
      a = $urandom;
      a[9:0] = 10'(i * 4);
      run_op(mk(0, 1, 0, 0, 0, 5'($urandom), $urandom, a), "fill");
    end

    // Store then load
    run_op(mk(0, 1, 0, 0, 0, 5'd0, 32'hDEADBEEF, 32'h8), "sw8");
    run_op(mk(1, 0, 1, 1, 0, 5'd3, 32'h0, 32'h8), "lw8");
    // Wrap
    run_op(mk(0, 1, 0, 0, 0, 5'd0, 32'h1234, 32'h400), "sw_wrap");
    run_op(mk(1, 0, 1, 1, 0, 5'd4, 32'h0, 32'h0), "lw_wrap");
    // Misaligned
    run_op(mk(1, 0, 1, 1, 0, 5'd5, 32'h0, 32'h6), "lw_mis");
    // Overflow store suppressed
    run_op(mk(0, 1, 0, 0, 0, 5'd0, 32'd5, 32'h10), "sw10");
    run_op(mk(1, 1, 0, 0, 1, 5'd6, 32'h99, 32'h10), "sw_ovf");
    run_op(mk(1, 0, 1, 1, 0, 5'd7, 32'h0, 32'h10), "lw10");
    // Both exceptions
    run_op(mk(1, 1, 0, 0, 1, 5'd8, 32'h55, 32'h13), "ovf_mis");

    // Reset mid-access
    run_op(mk(0, 1, 0, 0, 0, 5'd0, 32'd3, 32'h20), "sw20");
    ex_mem_reg = mk(0, 1, 0, 0, 0, 5'd0, 32'h77, 32'h20);
    ex_valid   = 1'b1;
    @(negedge clk);
    chk("abort stall_pre", 75'(stall_out), 75'(1));
    rst      = 1'b1;
    ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort stall", 75'(stall_out), 75'(0));
    chk("abort wb", 75'(wb_valid), 75'(0));
    idle_cycle();
    idle_cycle();
    run_op(mk(1, 0, 1, 1, 0, 5'd9, 32'h0, 32'h20), "lw20");

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic mr, mw;
      mr = 1'($urandom);
      mw = 1'($urandom);
      run_op(mk(1'($urandom), mw, 1'($urandom), mr, ($urandom_range(0, 7) == 0),
                5'($urandom), $urandom, rnd_addr(mr | mw)), "rand");
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
